median_frame_sched: RTL and testbench
=====================================

Name: median_frame_sched

Overview:
- Frame-level controller that sequences the serial median datapath (MED_DSI/MED_DI in, MED_DSO/MED_DO out) over a whole image held in a source RAM.
- For each interior pixel it fetches the 3x3 neighbourhood, streams the 9 samples into the median unit, waits for the result and writes it to a destination RAM.
- Border pixels are copied unchanged.
- Sits between the image RAMs and the median filter; the top level only sees START/BUSY/DONE/ERR.

Parameters:
WIDTH, 8, pixel bit width
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
TIMEOUT, 64, max cycles to wait for MED_DSO after the last sample
(localparam) AW = $clog2(IMG_W*IMG_H), RAM address width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
START  in  1  one-cycle request to filter the frame; ignored while BUSY
BUSY  out  1  high from the cycle after accepted START until DONE
DONE  out  1  one-cycle pulse at end of frame
ERR  out  1  sticky; median unit timed out; cleared by next accepted START or RST
RD_EN  out  1  source RAM read strobe
RD_ADDR  out  AW  source address; RD_DATA valid the cycle after RD_EN
RD_DATA  in  WIDTH  source read data
WR_EN  out  1  destination RAM write strobe
WR_ADDR  out  AW  destination address
WR_DATA  out  WIDTH  destination write data
MED_DSI  out  1  sample-valid to median unit
MED_DI  out  WIDTH  sample to median unit
MED_DO  in  WIDTH  median result
MED_DSO  in  1  result-valid pulse from median unit

Behaviour:
- Reset (asynchronous, any state, including mid-frame): state IDLE; BUSY=DONE=ERR=RD_EN=WR_EN=MED_DSI=0; RD_ADDR=WR_ADDR=0; WR_DATA=MED_DI=0; coordinates x=y=0.
- States: IDLE, SEL, COPY_RD, COPY_WR, FETCH, WAIT, WRITE, NEXT, FIN.
- IDLE -> SEL on START. Clears ERR and x, y.
- SEL:
  - Border pixel (x=0, y=0, x=IMG_W-1 or y=IMG_H-1) -> COPY_RD.
  - Otherwise -> FETCH with k=0.
- COPY_RD: RD_EN=1, RD_ADDR=y*IMG_W+x; -> COPY_WR.
- COPY_WR: WR_EN=1, WR_ADDR=same address, WR_DATA=RD_DATA; -> NEXT.
- FETCH: 9 consecutive cycles, k=0..8.
  - RD_EN=1; RD_ADDR=(y+dy)*IMG_W+(x+dx), where dy=k/3-1 and dx=k%3-1 (row-major, top-left first).
  - MED_DSI is RD_EN delayed one cycle, and MED_DI=RD_DATA. MED_DSI is therefore high for exactly 9 contiguous cycles, the last one being the first WAIT cycle.
  - After k=8 -> WAIT.
- WAIT:
  - The timeout counter starts at 0 in the first WAIT cycle.
  - A MED_DSO seen in the first WAIT cycle (the one still carrying the 9th DSI) is accepted.
  - On MED_DSO=1: capture MED_DO into the result register; -> WRITE.
  - If the counter reaches TIMEOUT with no DSO: ERR=1 (sticky); -> FIN. The frame is aborted and no write is issued for that pixel.
- WRITE: WR_EN=1, WR_ADDR=y*IMG_W+x, WR_DATA=captured result; -> NEXT.
- NEXT:
  - Advance raster order: x+1; at x=IMG_W-1 wrap to x=0 and y+1.
  - At the last pixel (IMG_W-1, IMG_H-1) -> FIN; else -> SEL.
- FIN: DONE=1 for exactly one cycle, BUSY=0 in the same cycle; -> IDLE.
- BUSY is high in every state except IDLE and FIN.
- START in any state other than IDLE is ignored, with no effect on ERR.
- Handshake rules:
  - RD_EN and WR_EN are never high in the same cycle.
  - MED_DSI is never high outside the 9-cycle burst.
  - A MED_DSO outside WAIT is ignored.
- Address arithmetic is unsigned AW bits; interior-only neighbourhoods guarantee no under/overflow.
- Per-pixel cost:
  - Border: 3 cycles (COPY_RD, COPY_WR, NEXT) plus 1 SEL.
  - Interior: SEL + 9 FETCH + (L+1) WAIT + WRITE + NEXT, where L is the MED_DSO delay after the last DSI.

Decomposition:
- Shared package median_pkg:
  - state enum sched_state_t
  - neighbour offset constant arrays DX[0:8] and DY[0:8]
  - function for row-major address computation
- One sub-module, median_addr_gen:
  - x/y raster counters, border flag, neighbour index k
  - RD_ADDR/WR_ADDR generation
  - controlled by inc_k, clr_k and next_pix strobes from the FSM

Test Plan:
- IMG_W=IMG_H=3, all source pixels 0x55, bench median model with L=2 -> 8 border copies, 1 interior write of 0x55 at addr 4. DONE exactly once, ERR=0.
- 3x3 source 0,0,0,0,0xFF,0,0,0,0 (salt at centre) -> dest addr 4 = 0x00, border words unchanged. MED_DI sequence is addrs 0..8 in order, MED_DSI high 9 contiguous cycles.
- 4x4 ramp source (value=addr), model L=5 -> interior addrs 5,6,9,10 hold the true 3x3 medians, written in raster order. Total cycle count from START to DONE matches the per-pixel formula.
- Model never asserts MED_DSO, TIMEOUT=8 -> ERR=1 after 8 WAIT cycles, DONE pulses, no write to addr 4. Next START clears ERR.
- START pulsed repeatedly while BUSY -> ignored; a single frame completes with one DONE.
- RST asserted during FETCH (k=4) -> all outputs 0 immediately (asynchronous), state IDLE. A fresh START reprocesses the frame correctly.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and helpers for the frame-level median scheduler.
package median_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEL,
        COPY_RD,
        COPY_WR,
        FETCH,
        WAIT,
        WRITE,
        NEXT,
        FIN
    } sched_state_t;

    localparam int unsigned KW     = 4;
    localparam int unsigned LAST_K = 8;

    // 3x3 neighbour offsets, row-major, top-left first
    localparam int DX [0:8] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
    localparam int DY [0:8] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

    function automatic int unsigned row_major(input int unsigned x,
                                              input int unsigned y,
                                              input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/median_addr_gen.sv
// Raster position, neighbour index and RAM address generation for the scheduler.
// Addresses are registered from the post-edge counter values so they line up with the FSM state.
module median_addr_gen
    import median_pkg::*;
#(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_xy,
    input  logic          next_pix,
    input  logic          clr_k,
    input  logic          inc_k,
    input  logic          fetch_next,
    output logic [KW-1:0] k,
    output logic          border_c,
    output logic          last_c,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [KW-1:0] k_n;

    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
        return AW'(row_major(32'(px), 32'(py), IMG_W));
    endfunction

    // Only evaluated for interior pixels, so the signed offsets never go negative
    function automatic logic [AW-1:0] nb_addr(input logic [XW-1:0] px,
                                              input logic [YW-1:0] py,
                                              input logic [KW-1:0] pk);
        int nx;
        int ny;
        nx = int'(px) + DX[pk];
        ny = int'(py) + DY[pk];
        return AW'(row_major(unsigned'(nx), unsigned'(ny), IMG_W));
    endfunction

    always_comb begin
        x_n = x;
        y_n = y;
        k_n = k;
        if (clr_xy) begin
            x_n = '0;
            y_n = '0;
        end else if (next_pix) begin
            if (x == XW'(IMG_W - 1)) begin
                x_n = '0;
                y_n = (y == YW'(IMG_H - 1)) ? '0 : y + 1'b1;
            end else begin
                x_n = x + 1'b1;
            end
        end
        if (clr_k) begin
            k_n = '0;
        end else if (inc_k) begin
            k_n = k + 1'b1;
        end
    end

    assign border_c = (x == '0) || (y == '0) ||
                      (x == XW'(IMG_W - 1)) || (y == YW'(IMG_H - 1));
    assign last_c   = (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            k       <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            x       <= x_n;
            y       <= y_n;
            k       <= k_n;
            rd_addr <= fetch_next ? nb_addr(x_n, y_n, k_n) : pix_addr(x_n, y_n);
            wr_addr <= pix_addr(x_n, y_n);
        end
    end

endmodule

// File: rtl/median_frame_sched.sv
// Frame sequencer: copies border pixels and runs each interior 3x3 window through
// the serial median unit, writing results to the destination RAM.
module median_frame_sched
    import median_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned IMG_W   = 16,
    parameter  int unsigned IMG_H   = 16,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned AW      = $clog2(IMG_W * IMG_H)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             RD_EN,
    output logic [AW-1:0]    RD_ADDR,
    input  logic [WIDTH-1:0] RD_DATA,
    output logic             WR_EN,
    output logic [AW-1:0]    WR_ADDR,
    output logic [WIDTH-1:0] WR_DATA,
    output logic             MED_DSI,
    output logic [WIDTH-1:0] MED_DI,
    input  logic [WIDTH-1:0] MED_DO,
    input  logic             MED_DSO
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    sched_state_t     state, state_n;
    logic             clr_xy, next_pix, clr_k, inc_k;
    logic             err_set, err_clr;
    logic [KW-1:0]    k;
    logic             border_c, last_c;
    logic [TW-1:0]    tmo_cnt;
    logic             copy_wr;
    logic [WIDTH-1:0] result;

    median_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr (
        .clk        (CLK),
        .rst        (RST),
        .clr_xy     (clr_xy),
        .next_pix   (next_pix),
        .clr_k      (clr_k),
        .inc_k      (inc_k),
        .fetch_next (state_n == FETCH),
        .k          (k),
        .border_c   (border_c),
        .last_c     (last_c),
        .rd_addr    (RD_ADDR),
        .wr_addr    (WR_ADDR)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        clr_xy   = 1'b0;
        next_pix = 1'b0;
        clr_k    = 1'b0;
        inc_k    = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_n = SEL;
                    clr_xy  = 1'b1;
                    err_clr = 1'b1;
                end
            end
            SEL: begin
                if (border_c) begin
                    state_n = COPY_RD;
                end else begin
                    state_n = FETCH;
                    clr_k   = 1'b1;
                end
            end
            COPY_RD: state_n = COPY_WR;
            COPY_WR: state_n = NEXT;
            FETCH: begin
                if (k == KW'(LAST_K)) begin
                    state_n = WAIT;
                end else begin
                    inc_k = 1'b1;
                end
            end
            // A DSO in the first WAIT cycle (still carrying the 9th sample) is accepted
            WAIT: begin
                if (MED_DSO) begin
                    state_n = WRITE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_n = FIN;
                    err_set = 1'b1;
                end
            end
            WRITE: state_n = NEXT;
            NEXT: begin
                next_pix = 1'b1;
                state_n  = last_c ? FIN : SEL;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs decoded from the next state so they are valid in the state's own cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            RD_EN   <= 1'b0;
            WR_EN   <= 1'b0;
            MED_DSI <= 1'b0;
            copy_wr <= 1'b0;
            tmo_cnt <= '0;
            result  <= '0;
        end else begin
            BUSY    <= (state_n != IDLE) && (state_n != FIN);
            DONE    <= (state_n == FIN);
            RD_EN   <= (state_n == COPY_RD) || (state_n == FETCH);
            WR_EN   <= (state_n == COPY_WR) || (state_n == WRITE);
            MED_DSI <= (state == FETCH);
            copy_wr <= (state_n == COPY_WR);
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;
            if (err_clr) begin
                ERR <= 1'b0;
            end else if (err_set) begin
                ERR <= 1'b1;
            end
            if ((state == WAIT) && MED_DSO) begin
                result <= MED_DO;
            end
        end
    end

    // RAM read data arrives the cycle after RD_EN, so it is forwarded without another stage
    assign MED_DI  = MED_DSI ? RD_DATA : '0;
    assign WR_DATA = !WR_EN ? '0 : (copy_wr ? RD_DATA : result);

endmodule

// File: tb/tb_median_frame_sched.sv
// Scoreboard bench for median_frame_sched on a 4x4 frame with a behavioural median unit.
module tb_median_frame_sched;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int TO   = 8;
    localparam int AW   = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          BUSY, DONE, ERR, RD_EN, WR_EN, MED_DSI;
    logic [AW-1:0] RD_ADDR, WR_ADDR;
    logic [7:0]    RD_DATA = 8'h00;
    logic [7:0]    WR_DATA, MED_DI;
    logic [7:0]    MED_DO = 8'h00;
    logic          MED_DSO = 1'b0;

    logic [7:0] src [0:NPIX-1];
    logic [7:0] dst [0:NPIX-1];
    wr_t        wr_q [$];
    logic [7:0] di_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int model_l = 2;
    bit model_en = 1'b1;

    median_frame_sched #(
        .WIDTH   (8),
        .IMG_W   (W),
        .IMG_H   (H),
        .TIMEOUT (TO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .RD_EN   (RD_EN),
        .RD_ADDR (RD_ADDR),
        .RD_DATA (RD_DATA),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA),
        .MED_DSI (MED_DSI),
        .MED_DI  (MED_DI),
        .MED_DO  (MED_DO),
        .MED_DSO (MED_DSO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous source RAM
    always @(posedge CLK) if (RD_EN) RD_DATA <= src[RD_ADDR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] median9(input logic [7:0] v [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = v;
        for (int i = 1; i < 9; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        return a[4];
    endfunction

    // Write monitor: destination RAM plus write-scoreboard compare
    initial begin
        wr_t e;
        forever begin
            @(negedge CLK);
            if (WR_EN) begin
                wr_cnt++;
                dst[WR_ADDR] = WR_DATA;
                chk("rd_wr_exclusive", 32'(RD_EN), 0);
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'(wr_q.size()), 1);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                    chk("wr_data", 32'(WR_DATA), 32'(e.data));
                end
            end
            if (DONE) begin
                done_cnt++;
                chk("busy_low_at_done", 32'(BUSY), 0);
            end
        end
    end

    // Median unit model with DSO latency model_l after the 9th sample; also checks MED_DI stream
    initial begin
        logic [7:0] samp [9];
        logic [7:0] med;
        int ns, pend, run;
        ns = 0; pend = 0; run = 0; med = 8'h00;
        forever begin
            @(negedge CLK);
            MED_DSO = 1'b0;
            if (RST) begin
                ns = 0; pend = 0; run = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin MED_DSO = 1'b1; MED_DO = med; end
                end
                if (MED_DSI) begin
                    if (di_q.size() == 0) chk("di_unexpected", 32'(di_q.size()), 1);
                    else chk("med_di", 32'(MED_DI), 32'(di_q.pop_front()));
                    samp[ns] = MED_DI;
                    ns++;
                    run++;
                    if (ns == 9) begin
                        ns  = 0;
                        med = median9(samp);
                        if (model_en) begin
                            if (model_l == 0) begin MED_DSO = 1'b1; MED_DO = med; end
                            else pend = model_l;
                        end
                    end
                end else if (run > 0) begin
                    chk("dsi_burst_len", 32'(run), 9);
                    run = 0;
                end
            end
        end
    end

    // Push expected writes / samples for one frame and compute START->DONE cycle count
    task automatic build_expect(input int l, input bit en, output int exp_cyc, output int nwr);
        int x, y;
        bit stop;
        wr_t e;
        logic [7:0] win [9];
        exp_cyc = 1; nwr = 0; stop = 1'b0;
        for (int p = 0; p < NPIX && !stop; p++) begin
            x = p % W;
            y = p / W;
            if (x == 0 || y == 0 || x == W - 1 || y == H - 1) begin
                e.addr = AW'(p); e.data = src[p];
                wr_q.push_back(e);
                nwr++;
                exp_cyc += 4;
            end else begin
                for (int k = 0; k < 9; k++) begin
                    win[k] = src[(y + k / 3 - 1) * W + x + k % 3 - 1];
                    di_q.push_back(win[k]);
                end
                if (en) begin
                    e.addr = AW'(p); e.data = median9(win);
                    wr_q.push_back(e);
                    nwr++;
                    exp_cyc += 13 + l;
                end else begin
                    exp_cyc += 10 + TO;
                    stop = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input string tag, input int l, input bit en, input bit spam,
                             output int meas);
        int exp_cyc, nwr, t0, dc0, wc0;
        bit got;
        model_l = l; model_en = en;
        build_expect(l, en, exp_cyc, nwr);
        dc0 = done_cnt; wc0 = wr_cnt;
        @(negedge CLK); START = 1'b1; t0 = cyc;
        @(negedge CLK); START = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(BUSY), 1);
        chk({tag, "_err_cleared"}, 32'(ERR), 0);
        got = 1'b0; meas = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge CLK);
            if (DONE) begin got = 1'b1; meas = cyc - t0; end
            START = spam && !got && (i % 3 == 0);
        end
        START = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 1);
        chk({tag, "_cycles"}, 32'(meas), 32'(exp_cyc));
        chk({tag, "_err"}, 32'(ERR), 32'(!en));
        repeat (4) @(negedge CLK);
        chk({tag, "_done_count"}, 32'(done_cnt - dc0), 1);
        chk({tag, "_write_count"}, 32'(wr_cnt - wc0), 32'(nwr));
        chk({tag, "_wr_q_empty"}, 32'(wr_q.size()), 0);
        chk({tag, "_di_q_empty"}, 32'(di_q.size()), 0);
        chk({tag, "_idle_busy"}, 32'(BUSY), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},    32'(BUSY), 0);
        chk({tag, "_done"},    32'(DONE), 0);
        chk({tag, "_err"},     32'(ERR), 0);
        chk({tag, "_rd_en"},   32'(RD_EN), 0);
        chk({tag, "_wr_en"},   32'(WR_EN), 0);
        chk({tag, "_med_dsi"}, 32'(MED_DSI), 0);
        chk({tag, "_rd_addr"}, 32'(RD_ADDR), 0);
        chk({tag, "_wr_addr"}, 32'(WR_ADDR), 0);
        chk({tag, "_wr_data"}, 32'(WR_DATA), 0);
        chk({tag, "_med_di"},  32'(MED_DI), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int meas, exp_cyc, nwr;
        bit found;
        for (int i = 0; i < NPIX; i++) begin src[i] = 8'h00; dst[i] = 8'h00; end

        #2 RST = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Flat frame: every pixel 0x55
        for (int i = 0; i < NPIX; i++) src[i] = 8'h55;
        run_frame("flat", 2, 1'b1, 1'b0, meas);
        chk("flat_dst5", 32'(dst[5]), 32'h55);
        chk("flat_dst0", 32'(dst[0]), 32'h55);

        // Salt at one interior pixel is removed; START spammed while busy
        for (int i = 0; i < NPIX; i++) src[i] = 8'h00;
        src[5] = 8'hFF;
        run_frame("salt", 4, 1'b1, 1'b1, meas);
        chk("salt_dst5", 32'(dst[5]), 32'h00);
        chk("salt_dst6", 32'(dst[6]), 32'h00);
        chk("salt_dst10", 32'(dst[10]), 32'h00);

        // Ramp: value = address; medians equal the centre address
        for (int i = 0; i < NPIX; i++) src[i] = 8'(i);
        run_frame("ramp", 5, 1'b1, 1'b0, meas);
        chk("ramp_cycles_hand", 32'(meas), 121);
        chk("ramp_dst5", 32'(dst[5]), 5);
        chk("ramp_dst6", 32'(dst[6]), 6);
        chk("ramp_dst9", 32'(dst[9]), 9);
        chk("ramp_dst10", 32'(dst[10]), 10);
        chk("ramp_dst15", 32'(dst[15]), 15);

        // Median unit never answers: ERR set, frame aborted after pixel 4
        for (int i = 0; i < NPIX; i++) src[i] = 8'hA0 + 8'(i);
        dst[5] = 8'h3C;
        run_frame("timeout", 0, 1'b0, 1'b0, meas);
        chk("timeout_cycles_hand", 32'(meas), 39);
        chk("timeout_no_write5", 32'(dst[5]), 32'h3C);
        chk("timeout_err_sticky", 32'(ERR), 1);

        // Next START clears ERR and a normal frame runs
        run_frame("recover", 1, 1'b1, 1'b0, meas);
        chk("recover_dst5", 32'(dst[5]), 32'hA5);

        // Asynchronous reset in the middle of the fetch burst (k=4)
        for (int i = 0; i < NPIX; i++) src[i] = 8'(i);
        model_l = 3; model_en = 1'b1;
        build_expect(3, 1'b1, exp_cyc, nwr);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (RD_EN && RD_ADDR == AW'(5)) found = 1'b1;
        end
        chk("midfetch_reached", 32'(found), 1);
        chk("midfetch_dsi_active", 32'(MED_DSI), 1);
        #2 RST = 1'b1;
        #1 check_reset_outputs("midfetch_rst");
        wr_q.delete();
        di_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", 32'(BUSY), 0);
        run_frame("after_rst", 3, 1'b1, 1'b0, meas);
        chk("after_rst_dst6", 32'(dst[6]), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
